soqpsk_carrier_loop: RTL and testbench

- Second-order carrier loop filter downstream of the SOQPSK Viterbi trellis.
- Consumes the signed phaseError and devError words that the trellis updates on every other symbol enable.
- Produces a saturated frequency/phase correction word for the carrier NCO, a deviation-tracking estimate, and a lock indication.
- All state is symbol-rate, gated by the trellis error strobe.

---
 rtl/soqpsk_pkg.sv | 67 ++++++
 rtl/soqpsk_lock_det.sv | 59 +++++
 rtl/soqpsk_carrier_loop.sv | 133 +++++++++++++
 tb/tb_soqpsk_carrier_loop.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soqpsk_pkg.sv
// Shared widths, types and saturating arithmetic helpers for the SOQPSK carrier loop.
// Latency: none (combinational helpers only).
// Backpressure: none.
package soqpsk_pkg;
    localparam int ROT_BITS  = 10;
    localparam int ACC_BITS  = 32;
    localparam int OUT_BITS  = 16;
    localparam int LOCK_BITS = 8;
    localparam int MAX_SHIFT = ACC_BITS - ROT_BITS;

    typedef logic signed [ROT_BITS-1:0] err_t;
    typedef logic signed [ACC_BITS-1:0] acc_t;
    // One guard bit so a two-operand sum can never wrap before saturation.
    typedef logic signed [ACC_BITS:0]   sum_t;
    typedef logic signed [OUT_BITS-1:0] out_t;

    typedef struct packed {
        logic hit;
        acc_t val;
    } clamp_t;

    // Sign-extend an error word to accumulator width and shift it left; the
    // exponent is capped so the largest error still fits without overflow.
    function automatic acc_t shift_err(input err_t e, input logic [4:0] sh);
        logic [4:0] s;
        s = (sh > 5'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : sh;
        return acc_t'(e) <<< s;
    endfunction

    // a+b at ACC_BITS+1, saturated to the signed range of 'width' bits.
    function automatic sum_t sat_add(input acc_t a, input acc_t b, input int width);
        sum_t s;
        sum_t hi;
        sum_t lo;
        s  = sum_t'(a) + sum_t'(b);
        hi = (sum_t'(1) <<< (width - 1)) - sum_t'(1);
        lo = -hi - sum_t'(1);
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

    // Symmetric clamp to [-lim, +lim]; hit reports that the clamp engaged.
    function automatic clamp_t clamp_sym(input sum_t x, input logic [ACC_BITS-2:0] lim);
        clamp_t r;
        sum_t   l;
        l     = sum_t'({2'b00, lim});
        r.hit = 1'b1;
        if (x > l) begin
            r.val = acc_t'(l);
        end else if (x < -l) begin
            r.val = acc_t'(-l);
        end else begin
            r.hit = 1'b0;
            r.val = acc_t'(x);
        end
        return r;
    endfunction

    function automatic out_t acc_msbs(input acc_t v);
        return v[ACC_BITS-1 -: OUT_BITS];
    endfunction
endpackage

// File: rtl/soqpsk_lock_det.sv
// Lock detector: |phase error| vs threshold drives an up-1/down-2 counter with hysteresis.
// Latency: lock updates on the clock edge that samples err_vld.
// Backpressure: none; accepts an error on every cycle err_vld is high.
// Ports: err_vld/phase_err sample strobe and word, thresh in-band limit,
//        clear synchronous zeroing (loop open), lock output.
module soqpsk_lock_det
    import soqpsk_pkg::*;
(
    input  logic                clk,
    input  logic                resetN,
    input  logic                err_vld,
    input  logic                clear,
    input  err_t                phase_err,
    input  logic [ROT_BITS-2:0] thresh,
    output logic                lock
);
    logic [LOCK_BITS-1:0] cnt_q, cnt_d;
    logic                 lock_q, lock_d;
    logic signed [ROT_BITS:0] err_ext;
    logic        [ROT_BITS:0] mag;
    logic                     in_band;

    always_comb begin
        // One extra bit so that the most negative error has a representable magnitude.
        err_ext = {phase_err[ROT_BITS-1], phase_err};
        mag     = err_ext[ROT_BITS] ? $unsigned(-err_ext) : $unsigned(err_ext);
        in_band = (mag < {2'b00, thresh});
        cnt_d   = cnt_q;
        lock_d  = lock_q;
        if (clear) begin
            cnt_d  = '0;
            lock_d = 1'b0;
        end else if (err_vld) begin
            if (in_band) begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = (cnt_q < LOCK_BITS'(2)) ? '0 : cnt_q - LOCK_BITS'(2);
            end
            // Hysteresis: only the extremes change the lock state.
            if (cnt_d == '1) begin
                lock_d = 1'b1;
            end else if (cnt_d == '0) begin
                lock_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
        end
    end

    assign lock = lock_q;
endmodule

// File: rtl/soqpsk_carrier_loop.sv
// Second-order carrier loop filter: lead/lag PI path to NCO, deviation integrator, lock detect.
// Latency: errEn at cycle n gives freqOut/devEst/outValid at n+3; lockDetect at n+1.
// Backpressure: none; errEn may be high every cycle, one outValid pulse per errEn.
// Ports: errEn/phaseError/devError trellis errors; loopEnable, clearAcc controls;
//        leadExp/lagExp/devExp gains; limit lag clamp; lockThresh lock band;
//        freqOut/devEst/outValid results; limitFlag sticky clamp hit; lockDetect.
module soqpsk_carrier_loop
    import soqpsk_pkg::*;
(
    input  logic                clk,
    input  logic                resetN,
    input  logic                errEn,
    input  err_t                phaseError,
    input  err_t                devError,
    input  logic                loopEnable,
    input  logic                clearAcc,
    input  logic [4:0]          leadExp,
    input  logic [4:0]          lagExp,
    input  logic [4:0]          devExp,
    input  logic [ACC_BITS-2:0] limit,
    input  logic [ROT_BITS-2:0] lockThresh,
    output out_t                freqOut,
    output out_t                devEst,
    output logic                outValid,
    output logic                limitFlag,
    output logic                lockDetect
);
    acc_t       lead_term_q, lead_term_d;
    acc_t       lag_term_q,  lag_term_d;
    acc_t       dev_term_q,  dev_term_d;
    acc_t       lead_dly_q,  lead_dly_d;
    acc_t       lag_acc_q,   lag_acc_d;
    acc_t       dev_acc_q,   dev_acc_d;
    out_t       freq_q,      freq_d;
    out_t       dev_est_q,   dev_est_d;
    logic [2:0] vld_q,       vld_d;
    logic       limit_flag_q, limit_flag_d;
    clamp_t     lag_clamp;

    always_comb begin
        vld_d        = {vld_q[1:0], errEn & loopEnable};
        lead_term_d  = lead_term_q;
        lag_term_d   = lag_term_q;
        dev_term_d   = dev_term_q;
        lead_dly_d   = lead_dly_q;
        lag_acc_d    = lag_acc_q;
        dev_acc_d    = dev_acc_q;
        limit_flag_d = limit_flag_q;
        freq_d       = freq_q;
        dev_est_d    = dev_est_q;
        lag_clamp    = clamp_sym(sum_t'(lag_acc_q) + sum_t'(lag_term_q), limit);

        // Stage 1: scale the error words.
        if (errEn) begin
            lead_term_d = shift_err(phaseError, leadExp);
            lag_term_d  = shift_err(phaseError, lagExp);
            dev_term_d  = shift_err(devError, devExp);
        end

        // Stage 2: integrate. The lead term is delayed one stage so it pairs
        // with the lag value that includes the same sample.
        if (vld_q[0]) begin
            lead_dly_d = lead_term_q;
            lag_acc_d  = lag_clamp.val;
            dev_acc_d  = acc_t'(sat_add(dev_acc_q, dev_term_q, ACC_BITS));
            if (lag_clamp.hit) begin
                limit_flag_d = 1'b1;
            end
        end
        // Clear beats a same-cycle accumulate and any clamp it would have flagged.
        if (clearAcc) begin
            lag_acc_d    = '0;
            limit_flag_d = 1'b0;
        end

        // Stage 3: proportional + integral sum to the NCO.
        if (vld_q[1]) begin
            freq_d    = acc_msbs(acc_t'(sat_add(lag_acc_q, lead_dly_q, ACC_BITS)));
            dev_est_d = acc_msbs(dev_acc_q);
        end

        // Open loop: drop in-flight samples and restart from zero state.
        if (!loopEnable) begin
            vld_d        = '0;
            lag_acc_d    = '0;
            dev_acc_d    = '0;
            limit_flag_d = 1'b0;
            freq_d       = '0;
            dev_est_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lead_term_q  <= '0;
            lag_term_q   <= '0;
            dev_term_q   <= '0;
            lead_dly_q   <= '0;
            lag_acc_q    <= '0;
            dev_acc_q    <= '0;
            freq_q       <= '0;
            dev_est_q    <= '0;
            vld_q        <= '0;
            limit_flag_q <= 1'b0;
        end else begin
            lead_term_q  <= lead_term_d;
            lag_term_q   <= lag_term_d;
            dev_term_q   <= dev_term_d;
            lead_dly_q   <= lead_dly_d;
            lag_acc_q    <= lag_acc_d;
            dev_acc_q    <= dev_acc_d;
            freq_q       <= freq_d;
            dev_est_q    <= dev_est_d;
            vld_q        <= vld_d;
            limit_flag_q <= limit_flag_d;
        end
    end

    soqpsk_lock_det u_lock_det (
        .clk       (clk),
        .resetN    (resetN),
        .err_vld   (errEn & loopEnable),
        .clear     (~loopEnable),
        .phase_err (phaseError),
        .thresh    (lockThresh),
        .lock      (lockDetect)
    );

    assign freqOut   = freq_q;
    assign devEst    = dev_est_q;
    assign outValid  = vld_q[2];
    assign limitFlag = limit_flag_q;
endmodule

// File: tb/tb_soqpsk_carrier_loop.sv
// Scoreboard bench for soqpsk_carrier_loop: a longint reference model predicts
// each output at drive time; the monitor pops and compares on every outValid.
module tb_soqpsk_carrier_loop;
    import soqpsk_pkg::*;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic                clk = 1'b0;
    logic                resetN;
    logic                errEn;
    logic signed [9:0]   phaseError;
    logic signed [9:0]   devError;
    logic                loopEnable;
    logic                clearAcc;
    logic [4:0]          leadExp;
    logic [4:0]          lagExp;
    logic [4:0]          devExp;
    logic [30:0]         limit;
    logic [8:0]          lockThresh;
    logic signed [15:0]  freqOut;
    logic signed [15:0]  devEst;
    logic                outValid;
    logic                limitFlag;
    logic                lockDetect;

    soqpsk_carrier_loop dut (
        .clk        (clk),
        .resetN     (resetN),
        .errEn      (errEn),
        .phaseError (phaseError),
        .devError   (devError),
        .loopEnable (loopEnable),
        .clearAcc   (clearAcc),
        .leadExp    (leadExp),
        .lagExp     (lagExp),
        .devExp     (devExp),
        .limit      (limit),
        .lockThresh (lockThresh),
        .freqOut    (freqOut),
        .devEst     (devEst),
        .outValid   (outValid),
        .limitFlag  (limitFlag),
        .lockDetect (lockDetect)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint freq;
        longint dev;
        int     issue;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;
    int     n_pulses = 0;
    int     pulses0;

    // Reference model state
    longint m_lag = 0;
    longint m_dev = 0;
    bit     m_flag = 0;
    int     m_cnt = 0;
    bit     m_lock = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint act, input longint want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, want);
        end
    endtask

    function automatic longint shl(input longint e, input int x);
        int s;
        s = (x > 22) ? 22 : x;
        return e * (longint'(1) << s);
    endfunction

    function automatic longint sat32(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    task automatic model_zero();
        m_lag = 0; m_dev = 0; m_flag = 0; m_cnt = 0; m_lock = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a posedge; errEn is high for exactly the following cycle.
    // clr_race raises clearAcc in the cycle the lag update happens.
    task automatic drive_err(input int pe, input int de, input bit push, input bit clr_race);
        longint s;
        longint lim;
        int     mag;
        exp_t   e;
        phaseError = 10'(pe);
        devError   = 10'(de);
        errEn      = 1'b1;
        mag = (pe < 0) ? -pe : pe;
        if (mag < int'(lockThresh)) m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
        else                        m_cnt = (m_cnt < 2) ? 0 : m_cnt - 2;
        if (m_cnt == 255) m_lock = 1;
        else if (m_cnt == 0) m_lock = 0;
        if (push) begin
            lim = longint'(limit);
            if (clr_race) begin
                m_lag = 0;
                m_flag = 0;
            end else begin
                s = m_lag + shl(pe, lagExp);
                if (s > lim) begin
                    m_lag = lim; m_flag = 1;
                end else if (s < -lim) begin
                    m_lag = -lim; m_flag = 1;
                end else begin
                    m_lag = s;
                end
            end
            m_dev   = sat32(m_dev + shl(de, devExp));
            e.freq  = sat32(m_lag + shl(pe, leadExp)) >>> 16;
            e.dev   = m_dev >>> 16;
            e.issue = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        errEn = 1'b0;
        if (clr_race) begin
            clearAcc = 1'b1;
            @(posedge clk);
            #1;
            clearAcc = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (resetN && outValid) begin
            n_pulses++;
            check_val("sb_has_entry", longint'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check_val("freqOut", freqOut, mon_e.freq);
                check_val("devEst", devEst, mon_e.dev);
                check_val("latency", cyc - mon_e.issue, 3);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN = 1'b0; errEn = 1'b0; phaseError = '0; devError = '0;
        loopEnable = 1'b1; clearAcc = 1'b0;
        leadExp = 5'd0; lagExp = 5'd0; devExp = 5'd0;
        limit = '1; lockThresh = 9'd32;
        idle(3);
        check_val("rst_freq", freqOut, 0);
        check_val("rst_vld", outValid, 0);
        check_val("rst_lock", lockDetect, 0);
        resetN = 1'b1;
        idle(2);

        // Step response, strobes spaced two cycles apart
        leadExp = 5'd12; lagExp = 5'd4; devExp = 5'd6;
        for (int k = 1; k <= 4; k++) begin
            drive_err(64, 5, 1, 0);
            idle(1);
        end
        idle(4);
        check_val("step_lag", dut.lag_acc_q, 64 * 16 * 4);
        check_val("step_pulses", n_pulses, 4);

        // Asynchronous reset mid-run
        #2;
        resetN = 1'b0;
        #1;
        check_val("arst_freq", freqOut, 0);
        check_val("arst_vld", outValid, 0);
        check_val("arst_lag", dut.lag_acc_q, 0);
        sb.delete();
        model_zero();
        @(posedge clk);
        #1;
        resetN = 1'b1;
        pulses0 = n_pulses;
        idle(10);
        check_val("idle_freq", freqOut, 0);
        check_val("idle_pulses", n_pulses, pulses0);

        // Clamp and saturation
        lagExp = 5'd22; devExp = 5'd22; limit = 31'(1 << 28);
        repeat (3) begin drive_err(511, 511, 1, 0); idle(1); end
        idle(3);
        check_val("clamp_hi", dut.lag_acc_q, 64'sd268435456);
        check_val("flag_hi", limitFlag, 1);
        check_val("dev_sat_hi", devEst, 32767);
        repeat (3) begin drive_err(-512, -512, 1, 0); idle(1); end
        idle(3);
        check_val("clamp_lo", dut.lag_acc_q, -64'sd268435456);
        check_val("flag_lo", limitFlag, 1);
        check_val("dev_sat_lo", devEst, -32768);
        clearAcc = 1'b1;
        idle(1);
        clearAcc = 1'b0;
        m_lag = 0; m_flag = 0;
        check_val("clr_lag", dut.lag_acc_q, 0);
        check_val("clr_flag", limitFlag, 0);

        // Lock hysteresis
        leadExp = 5'd0; lagExp = 5'd0; devExp = 5'd0; limit = '1;
        for (int i = 1; i <= 255; i++) begin
            drive_err((i % 2 == 1) ? 10 : -10, 0, 1, 0);
            if (i == 254) check_val("lock_254", lockDetect, 0);
        end
        check_val("lock_255", lockDetect, 1);
        for (int i = 1; i <= 128; i++) begin
            drive_err(-100, 0, 1, 0);
            if (i == 127) check_val("unlock_127", lockDetect, 1);
        end
        check_val("unlock_128", lockDetect, 0);
        idle(4);

        // clearAcc racing a lag update
        leadExp = 5'd12; lagExp = 5'd4;
        drive_err(200, 7, 1, 1);
        idle(3);
        check_val("race_lag", dut.lag_acc_q, 0);

        // loopEnable dropped one cycle after errEn
        pulses0 = n_pulses;
        drive_err(200, 7, 0, 0);
        loopEnable = 1'b0;
        idle(1);
        loopEnable = 1'b1;
        model_zero();
        idle(5);
        check_val("open_freq", freqOut, 0);
        check_val("open_dev", devEst, 0);
        check_val("open_pulses", n_pulses, pulses0);

        // Back-to-back random errors with over-range exponents
        leadExp = 5'd27; lagExp = 5'd20; devExp = 5'd31; limit = 31'(1 << 30);
        pulses0 = n_pulses;
        for (int i = 0; i < 10; i++) begin
            drive_err(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512, 1, 0);
        end
        idle(6);
        check_val("b2b_pulses", n_pulses - pulses0, 10);
        check_val("b2b_lag", dut.lag_acc_q, m_lag);
        check_val("b2b_flag", limitFlag, m_flag);
        check_val("b2b_lock", lockDetect, m_lock);

        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
        check_val("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
